// File: rtl/fxp_mult_sched.sv
// fxp_mult_sched: N requesters share one LAT-stage fixed-point multiplier.
// A round-robin arbiter grants at most one operand pair per cycle. Results
// leave the last stage tagged with the issuing requester index, and a stall
// at the consumer freezes the whole pipeline.
module fxp_mult_sched #(
  parameter int W   = 32,
  parameter int D   = 16,
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*W-1:0]         req_left,
  input  logic [N*W-1:0]         req_right,
  output logic                   resp_valid,
  output logic [$clog2(N)-1:0]   resp_id,
  output logic [W-1:0]           resp_out,
  input  logic                   resp_ready,
  output logic                   busy
);

  localparam int IDW = $clog2(N);

  // Requester index reached by stepping k places from p, wrapping modulo N.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[IDW-1:0];
  endfunction

  // Pipeline state: one {valid, id, data} entry per stage.
  logic [LAT-1:0] r_vld;
  logic [IDW-1:0] r_id   [LAT];
  logic [W-1:0]   r_data [LAT];
  logic [IDW-1:0] r_ptr;

  logic [W-1:0]   w_left  [N];
  logic [W-1:0]   w_right [N];
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_any;
  logic           w_advance;
  logic [IDW-1:0] w_ptr_next;
  logic [W-1:0]   w_sel_l;
  logic [W-1:0]   w_sel_r;
  logic signed [W+D-1:0] w_a_ext;
  logic signed [W+D-1:0] w_b_ext;
  logic signed [W+D-1:0] w_prod;
  logic [W-1:0]   w_res;

  // Unpack the flat operand buses into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_left[gi]  = req_left[gi*W +: W];
      assign w_right[gi] = req_right[gi*W +: W];
    end
  endgenerate

  // The whole pipeline moves unless the consumer refuses a valid result.
  assign w_advance = !(r_vld[LAT-1] && !resp_ready);

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_any && req_valid[wrap_idx(r_ptr, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
    if (w_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_next = (w_gnt_idx == IDW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign req_ready  = (w_advance && !reset) ? w_grant : '0;

  // Multiply sits in front of stage 0: sign-extend by D, keep W+D bits,
  // and take the window above the fractional bits (truncating, wrapping).
  assign w_sel_l = w_left[w_gnt_idx];
  assign w_sel_r = w_right[w_gnt_idx];
  assign w_a_ext = {{D{w_sel_l[W-1]}}, w_sel_l};
  assign w_b_ext = {{D{w_sel_r[W-1]}}, w_sel_r};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_res   = W'(w_prod >> D);

  // Pipeline shift and arbiter pointer update; both freeze during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_vld <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_id[s]   <= '0;
        r_data[s] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0]  <= w_any;
      r_id[0]   <= w_gnt_idx;
      r_data[0] <= w_res;
      for (int s = 1; s < LAT; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_id[s]   <= r_id[s-1];
        r_data[s] <= r_data[s-1];
      end
      if (w_any) r_ptr <= w_ptr_next;
    end
  end

  assign resp_valid = r_vld[LAT-1];
  assign resp_id    = r_id[LAT-1];
  assign resp_out   = r_data[LAT-1];
  assign busy       = |r_vld;

endmodule

// File: tb/tb_fxp_mult_sched.sv
// Directed bench for fxp_mult_sched at default parameters (W=32, D=16, N=4, LAT=3).
module tb_fxp_mult_sched;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_left;
  logic [N*W-1:0] req_right;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_out;
  logic           resp_ready;
  logic           busy;

  int checks = 0;
  int errors = 0;

  fxp_mult_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_out(resp_out),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    req_left[i*W +: W]  = l;
    req_right[i*W +: W] = r;
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_left = '0; req_right = '0; resp_ready = 1'b1;

    // Reset: req_ready stays low even with every requester valid.
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    tick;
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_id", 64'(resp_id), 64'h0);
    check("rst_resp_out", 64'(resp_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    reset = 1'b0; req_valid = '0;
    tick;

    // Single request from requester 2: 1.5 * 2.0 = 3.0.
    set_ops(2, 32'h00018000, 32'h00020000);
    req_valid = 4'b0100;
    #1;
    $display("txn single: req2 0x00018000*0x00020000");
    check("single_ready", 64'(req_ready), 64'h4);
    tick; req_valid = '0;
    check("single_c1_valid", 64'(resp_valid), 64'h0);
    check("single_c1_busy", 64'(busy), 64'h1);
    tick;
    check("single_c2_valid", 64'(resp_valid), 64'h0);
    tick;
    check("single_valid", 64'(resp_valid), 64'h1);
    check("single_id", 64'(resp_id), 64'h2);
    check("single_out", 64'(resp_out), 64'h00030000);
    tick;
    check("single_done_valid", 64'(resp_valid), 64'h0);
    check("single_done_busy", 64'(busy), 64'h0);

    // Signed products back to back from requester 0 (ptr is 3 here).
    set_ops(0, 32'hFFFF0000, 32'h00008000);
    req_valid = 4'b0001;
    #1;
    $display("txn signed: req0 0xFFFF0000*0x00008000");
    check("neg_ready", 64'(req_ready), 64'h1);
    tick;
    set_ops(0, 32'h7FFF0000, 32'h00020000);
    #1;
    $display("txn signed: req0 0x7FFF0000*0x00020000");
    check("wrap_ready", 64'(req_ready), 64'h1);
    tick; req_valid = '0;
    tick;
    check("neg_valid", 64'(resp_valid), 64'h1);
    check("neg_out", 64'(resp_out), 64'hFFFF8000);
    tick;
    check("wrap_valid", 64'(resp_valid), 64'h1);
    check("wrap_out", 64'(resp_out), 64'hFFFE0000);
    tick;

    // Rotation from reset, with a 5-cycle stall once the pipeline is full.
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, W'((i + 1) << 16), 32'h00010000);
    req_valid = 4'hF;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      resp_ready = !(t >= 8 && t < 13);
      #1;
      if (!resp_ready) begin
        $display("txn stall: cycle %0d", t);
        check("stall_ready", 64'(req_ready), 64'h0);
        check("stall_valid", 64'(resp_valid), 64'h1);
        check("stall_id", 64'(resp_id), 64'h1);
        check("stall_out", 64'(resp_out), 64'h00020000);
      end else begin
        $display("txn rot: accept %0d", n);
        check("rot_grant", 64'(req_ready), 64'(1 << (n % 4)));
        if (n >= 3) begin
          check("rot_valid", 64'(resp_valid), 64'h1);
          check("rot_id", 64'(resp_id), 64'((n - 3) % 4));
          check("rot_out", 64'(resp_out), 64'((((n - 3) % 4) + 1) << 16));
        end else begin
          check("rot_fill_valid", 64'(resp_valid), 64'h0);
        end
        n++;
      end
      tick;
    end
    req_valid = '0;
    for (int d = 0; d < 3; d++) begin
      check("rot_drain_id", 64'(resp_id), 64'((n - 3 + d) % 4));
      tick;
    end
    check("rot_drain_busy", 64'(busy), 64'h0);

    // Reset mid-flight: two accepts from requester 3, then reset.
    set_ops(3, 32'h00050000, 32'h00010000);
    req_valid = 4'b1000;
    tick; tick;
    req_valid = '0;
    reset = 1'b1; tick; reset = 1'b0;
    $display("txn midreset: two in flight discarded");
    check("mr_valid", 64'(resp_valid), 64'h0);
    check("mr_busy", 64'(busy), 64'h0);
    for (int d = 0; d < 4; d++) begin
      check("mr_no_result", 64'(resp_valid), 64'h0);
      tick;
    end
    req_valid = 4'b1010;
    #1;
    check("mr_next_grant", 64'(req_ready), 64'h2);
    tick; req_valid = '0;
    tick; tick;
    check("mr_result_id", 64'(resp_id), 64'h1);
    tick;
    check("mr_drained", 64'(busy), 64'h0);

    // Sparse traffic: requester 1 every third cycle, four requests.
    n = 0;
    for (int t = 0; t < 14; t++) begin
      if (t % 3 == 0 && t <= 9) begin
        set_ops(1, W'((t / 3 + 1) << 16), 32'h00030000);
        req_valid = 4'b0010;
      end else begin
        req_valid = '0;
      end
      #1;
      if (req_valid != 0) begin
        $display("txn sparse: accept %0d", t / 3);
        check("sp_ready", 64'(req_ready), 64'h2);
      end
      if (t >= 3 && t % 3 == 0) begin
        check("sp_valid", 64'(resp_valid), 64'h1);
        check("sp_id", 64'(resp_id), 64'h1);
        check("sp_out", 64'(resp_out), 64'((3 * (t / 3)) << 16));
      end else begin
        check("sp_idle_valid", 64'(resp_valid), 64'h0);
      end
      if (t == 12) check("sp_busy_last", 64'(busy), 64'h1);
      if (t == 13) check("sp_busy_off", 64'(busy), 64'h0);
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
